// File: rtl/shift_arbiter.sv
// shift_arbiter
//
// Shares one left_shifter between NUM_REQ requester streams. Requests are
// granted round-robin and the granted {data, shift_len} beat is held on the
// shifter input until accepted. The owner of every in-flight beat is queued in
// a tag FIFO, and each shifter result is steered back to that owner in issue
// order. A result that arrives with no outstanding tag sets a sticky error.
//
// Ports
//   clk, rstn          clock; synchronous active-low reset
//   req_tdata/tvalid/tready   per-requester {data, shift_len} input streams
//   sh_tdata/tvalid/tready    beat to the shared shifter
//   shr_tdata/tvalid/tready   result from the shared shifter
//   rsp_tdata                 shared result bus (pass-through of shr_tdata)
//   rsp_tvalid/tready         one-hot per-requester result handshake
//   err_orphan                sticky: result seen with the tag FIFO empty
//
// Optional build macro SHIFT_ARB_STATS_EN adds:
//   grant_cnt          NUM_REQ saturating 32-bit issue counters
//   max_inflight_seen  high-water mark of the in-flight count
//
// FSM states
//   state   | meaning
//   ST_IDLE | looking for a requester; grant and latch in the same cycle
//   ST_HOLD | beat held on sh_tdata with sh_tvalid=1 until sh_tready

module shift_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SHIFT_WIDTH  = 128,
    parameter int LEN_WIDTH    = 7,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic [NUM_REQ*(SHIFT_WIDTH+LEN_WIDTH)-1:0]   req_tdata,
    input  logic [NUM_REQ-1:0]                           req_tvalid,
    output logic [NUM_REQ-1:0]                           req_tready,
    output logic [SHIFT_WIDTH+LEN_WIDTH-1:0]             sh_tdata,
    output logic                                         sh_tvalid,
    input  logic                                         sh_tready,
    input  logic [SHIFT_WIDTH-1:0]                       shr_tdata,
    input  logic                                         shr_tvalid,
    output logic                                         shr_tready,
    output logic [SHIFT_WIDTH-1:0]                       rsp_tdata,
    output logic [NUM_REQ-1:0]                           rsp_tvalid,
    input  logic [NUM_REQ-1:0]                           rsp_tready,
    output logic                                         err_orphan
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]                        grant_cnt,
    output logic [$clog2(MAX_INFLIGHT):0]                max_inflight_seen
`endif
);

    localparam int BEAT_W = SHIFT_WIDTH + LEN_WIDTH;
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int PTR_W  = $clog2(MAX_INFLIGHT);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   grant, grant_nxt;
    logic [BEAT_W-1:0]  beat_q, beat_nxt;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W:0]     cand;

    logic [IDX_W-1:0]   tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_empty;
    logic               pending;
    logic               issue_room;
    logic               push, pop;
    logic [IDX_W-1:0]   head_tag;

    // Round-robin search: walk offsets from the highest down so that the
    // smallest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req_tvalid[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // A beat sitting in HOLD already owns a FIFO slot even before it is pushed.
    assign pending    = (state == ST_HOLD);
    assign issue_room = (count + CNT_W'(pending)) < CNT_W'(MAX_INFLIGHT);

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        beat_nxt   = beat_q;
        rr_ptr_nxt = rr_ptr;
        req_tready = '0;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rstn && issue_room && sel_found) begin
                    req_tready[sel_idx] = 1'b1;
                    grant_nxt           = sel_idx;
                    beat_nxt            = req_tdata[int'(sel_idx)*BEAT_W +: BEAT_W];
                    state_nxt           = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (sh_tready) begin
                    push       = 1'b1;
                    rr_ptr_nxt = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            beat_q <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            grant  <= grant_nxt;
            beat_q <= beat_nxt;
        end
    end

    assign sh_tvalid = (state == ST_HOLD);
    assign sh_tdata  = beat_q;

    // Tag FIFO. Storage needs no reset: every read is qualified by !fifo_empty.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign fifo_empty = (count == '0);
    assign head_tag   = tag_mem[rd_ptr];

    // Return path: strictly in issue order, so a stalled owner stalls everyone.
    always_comb begin
        rsp_tvalid = '0;
        shr_tready = 1'b0;
        if (!fifo_empty) begin
            rsp_tvalid[head_tag] = shr_tvalid;
            shr_tready           = rsp_tready[head_tag];
        end
    end

    assign rsp_tdata = shr_tdata;
    assign pop       = shr_tvalid & shr_tready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_orphan <= 1'b0;
        end else if (shr_tvalid && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] gcnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gcnt <= '0;
        end else if (push && (gcnt[grant] != 32'hFFFF_FFFF)) begin
            gcnt[grant] <= gcnt[grant] + 32'd1;
        end
    end

    assign grant_cnt = gcnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            max_inflight_seen <= '0;
        end else if (count > max_inflight_seen) begin
            max_inflight_seen <= count;
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a queue-based reference model predicts every
// output each cycle; directed scenarios pin a few literal expectations and a
// randomized phase exercises the arbiter against a 3-cycle shifter model.

module tb_shift_arbiter;

    localparam int N    = 4;
    localparam int SW   = 128;
    localparam int LW   = 7;
    localparam int BW   = SW + LW;
    localparam int MAXI = 8;
    localparam int LAT  = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N*BW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid;
    logic [N-1:0]    req_tready;
    logic [BW-1:0]   sh_tdata;
    logic            sh_tvalid;
    logic            sh_tready;
    logic [SW-1:0]   shr_tdata;
    logic            shr_tvalid;
    logic            shr_tready;
    logic [SW-1:0]   rsp_tdata;
    logic [N-1:0]    rsp_tvalid;
    logic [N-1:0]    rsp_tready;
    logic            err_orphan;
`ifdef SHIFT_ARB_STATS_EN
    logic [N*32-1:0] grant_cnt;
    logic [3:0]      max_inflight_seen;
`endif

    shift_arbiter #(
        .NUM_REQ(N), .SHIFT_WIDTH(SW), .LEN_WIDTH(LW), .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .sh_tdata(sh_tdata), .sh_tvalid(sh_tvalid), .sh_tready(sh_tready),
        .shr_tdata(shr_tdata), .shr_tvalid(shr_tvalid), .shr_tready(shr_tready),
        .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
        .err_orphan(err_orphan)
`ifdef SHIFT_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .max_inflight_seen(max_inflight_seen)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 0;

    // stimulus controls
    logic [BW-1:0] beat [N];
    int            budget [N];
    bit            rnd_req      = 0;
    int            sh_mode      = 1;   // 0 never ready, 1 always, 2 random
    bit            shr_en       = 1;
    bit            force_orphan = 0;
    bit            rsp_rand     = 0;
    logic [N-1:0]  rsp_force    = '1;

    // reference model
    bit            m_hold = 0;
    int            m_hold_port = 0;
    logic [BW-1:0] m_hold_beat = '0;
    int            m_rr = 0;
    int            tagq [$];
    logic [SW-1:0] resq [$];
    bit            m_err = 0;
    int            grant_log [$];
    int            rsp_log [$];

    typedef struct {
        logic [SW-1:0] res;
        int            rdy;
    } shr_item_t;
    shr_item_t     shq [$];

    // per-cycle expectations and captured outputs
    int            win;
    logic [N-1:0]  e_req, e_rsp;
    bit            e_shr_rdy;
    logic [N-1:0]  cap_req_tready, cap_rsp_tvalid;
    logic          cap_sh_tvalid, cap_shr_tready, cap_err;
    logic [BW-1:0] cap_sh_tdata;
    logic [SW-1:0] cap_rsp_tdata;

    function automatic logic [SW-1:0] shres(input logic [BW-1:0] b);
        logic [SW-1:0] d;
        d = b[BW-1:LW];
        return d << b[LW-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom, 7'($urandom)};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        if (rnd_req) begin
            for (int p = 0; p < N; p++) begin
                if (!req_tvalid[p] && $urandom_range(0, 3) == 0) begin
                    req_tvalid[p] = 1'b1;
                    beat[p]       = rand_beat();
                end
            end
        end
        for (int p = 0; p < N; p++) req_tdata[p*BW +: BW] = beat[p];
        sh_tready  = (sh_mode == 0) ? 1'b0 : (sh_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp_tready = rsp_rand ? N'($urandom) : rsp_force;
        if (force_orphan) begin
            shr_tvalid = 1'b1;
            shr_tdata  = {$urandom, $urandom, $urandom, $urandom};
        end else if (shr_en && shq.size() > 0 && shq[0].rdy <= cyc) begin
            shr_tvalid = 1'b1;
            shr_tdata  = shq[0].res;
        end else begin
            shr_tvalid = 1'b0;
            shr_tdata  = '0;
        end
    endtask

    task automatic eval_compare();
        e_req = '0;
        win   = -1;
        if (rstn && !m_hold && tagq.size() < MAXI) begin
            for (int k = 0; k < N; k++) begin
                int p = (m_rr + k) % N;
                if (win < 0 && req_tvalid[p]) win = p;
            end
        end
        if (win >= 0) e_req[win] = 1'b1;
        e_rsp     = '0;
        e_shr_rdy = 1'b0;
        if (tagq.size() > 0) begin
            e_rsp[tagq[0]] = shr_tvalid;
            e_shr_rdy      = rsp_tready[tagq[0]];
        end
        if (!cmp_en) return;
        chk("req_tready", 160'(cap_req_tready), 160'(e_req));
        chk("sh_tvalid", 160'(cap_sh_tvalid), 160'(m_hold));
        if (m_hold) chk("sh_tdata", 160'(cap_sh_tdata), 160'(m_hold_beat));
        chk("rsp_tvalid", 160'(cap_rsp_tvalid), 160'(e_rsp));
        chk("shr_tready", 160'(cap_shr_tready), 160'(e_shr_rdy));
        if (shr_tvalid && tagq.size() > 0) chk("rsp_tdata", 160'(cap_rsp_tdata), 160'(resq[0]));
        chk("err_orphan", 160'(cap_err), 160'(m_err));
    endtask

    task automatic advance();
        cyc++;
        if (!rstn) begin
            m_hold = 0;
            m_rr   = 0;
            m_err  = 0;
            tagq.delete();
            resq.delete();
            shq.delete();
            return;
        end
        if (shr_tvalid && cap_shr_tready && shq.size() > 0) void'(shq.pop_front());
        if (cap_sh_tvalid && sh_tready) shq.push_back('{res: shres(cap_sh_tdata), rdy: cyc + LAT});
        if (shr_tvalid && tagq.size() == 0) m_err = 1;
        if (shr_tvalid && tagq.size() > 0 && e_shr_rdy) begin
            rsp_log.push_back(tagq[0]);
            void'(tagq.pop_front());
            void'(resq.pop_front());
        end
        if (m_hold && sh_tready) begin
            tagq.push_back(m_hold_port);
            resq.push_back(shres(m_hold_beat));
            grant_log.push_back(m_hold_port);
            m_rr   = (m_hold_port + 1) % N;
            m_hold = 0;
        end else if (win >= 0) begin
            m_hold      = 1;
            m_hold_port = win;
            m_hold_beat = beat[win];
            if (rnd_req) begin
                if ($urandom_range(0, 2) == 0) req_tvalid[win] = 1'b0;
                else beat[win] = rand_beat();
            end else begin
                budget[win]--;
                if (budget[win] > 0) beat[win] = rand_beat();
                else req_tvalid[win] = 1'b0;
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        cap_req_tready = req_tready;
        cap_sh_tvalid  = sh_tvalid;
        cap_sh_tdata   = sh_tdata;
        cap_rsp_tvalid = rsp_tvalid;
        cap_rsp_tdata  = rsp_tdata;
        cap_shr_tready = shr_tready;
        cap_err        = err_orphan;
        eval_compare();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic set_req(input int p, input logic [SW-1:0] d, input logic [LW-1:0] l, input int n);
        req_tvalid[p] = 1'b1;
        beat[p]       = {d, l};
        budget[p]     = n;
    endtask

    task automatic set_req_rand(input int p, input int n);
        logic [BW-1:0] b;
        b = rand_beat();
        set_req(p, b[BW-1:LW], b[LW-1:0], n);
    endtask

    task automatic clear_reqs();
        req_tvalid = '0;
        for (int p = 0; p < N; p++) budget[p] = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        force_orphan = 0;
        clear_reqs();
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic wait_tags(input int n, input string name);
        int c = 0;
        while (tagq.size() < n && c < 100) begin step(); c++; end
        chk(name, 160'(c < 100), 160'(1));
    endtask

    task automatic drain(input string name);
        int c = 0;
        rnd_req = 0; sh_mode = 1; shr_en = 1; rsp_rand = 0; rsp_force = '1;
        while ((m_hold || tagq.size() > 0 || req_tvalid != '0) && c < 400) begin step(); c++; end
        chk(name, 160'(c < 400), 160'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int cnt [N];
        logic [BW-1:0] held;

        rstn = 1'b0;
        req_tvalid = '0;
        for (int p = 0; p < N; p++) begin beat[p] = '0; budget[p] = 0; end
        step();
        cmp_en = 1;
        do_reset();

        // reset state
        step();
        chk("rst_sh_tvalid", 160'(cap_sh_tvalid), 160'(0));
        chk("rst_rsp_tvalid", 160'(cap_rsp_tvalid), 160'(0));
        chk("rst_err", 160'(cap_err), 160'(0));
        chk("rst_shr_tready", 160'(cap_shr_tready), 160'(0));

        // single request: port 2, data 1, len 64
        set_req(2, 128'h1, 7'd64, 1);
        step();
        chk("single_grant", 160'(cap_req_tready), 160'(4'b0100));
        step();
        chk("single_sh_tvalid", 160'(cap_sh_tvalid), 160'(1));
        chk("single_sh_tdata", 160'(cap_sh_tdata), 160'({128'h1, 7'd64}));
        c = 0;
        while (cap_rsp_tvalid == '0 && c < 10) begin step(); c++; end
        chk("single_rsp_tvalid", 160'(cap_rsp_tvalid), 160'(4'b0100));
        chk("single_rsp_tdata", 160'(cap_rsp_tdata), 160'({64'h1, 64'h0}));
        chk("single_err", 160'(cap_err), 160'(0));
        drain("single_drain");

        // fairness: all ports continuously valid for 16 issues
        do_reset();
        grant_log.delete();
        for (int p = 0; p < N; p++) set_req_rand(p, 4);
        c = 0;
        while (grant_log.size() < 16 && c < 200) begin step(); c++; end
        for (int k = 0; k < 16; k++)
            chk("fair_order", (k < grant_log.size()) ? 160'(grant_log[k]) : 160'(99), 160'(k % 4));
        for (int p = 0; p < N; p++) cnt[p] = 0;
        foreach (grant_log[i]) cnt[grant_log[i]]++;
        for (int p = 0; p < N; p++) chk("fair_count", 160'(cnt[p]), 160'(4));
`ifdef SHIFT_ARB_STATS_EN
        step();
        for (int p = 0; p < N; p++) chk("fair_grant_cnt", 160'(grant_cnt[p*32 +: 32]), 160'(32'd4));
`endif
        drain("fair_drain");

        // HOLD stability with sh_tready low for 5 cycles
        sh_mode = 0;
        set_req_rand(1, 1);
        set_req_rand(3, 1);
        c = 0;
        while (!cap_sh_tvalid && c < 10) begin step(); c++; end
        held = cap_sh_tdata;
        chk("hold_first", 160'(held), 160'(m_hold_beat));
        repeat (5) begin
            step();
            chk("hold_tvalid", 160'(cap_sh_tvalid), 160'(1));
            chk("hold_tdata", 160'(cap_sh_tdata), 160'(held));
            chk("hold_tready", 160'(cap_req_tready), 160'(0));
        end
        sh_mode = 1;
        step();
        chk("hold_release", 160'(cap_sh_tvalid), 160'(1));
        step();
        chk("hold_idle", 160'(cap_sh_tvalid), 160'(0));
        chk("hold_next_grant", 160'(cap_req_tready), 160'(4'b1000));
        drain("hold_drain");

        // FIFO full: 8 in flight, 9th must wait for a pop
        do_reset();
        shr_en = 0;
        set_req_rand(0, 9);
        wait_tags(8, "full_fill");
        repeat (3) begin
            step();
            chk("full_blocked", 160'(cap_req_tready), 160'(0));
        end
`ifdef SHIFT_ARB_STATS_EN
        chk("full_high_water", 160'(max_inflight_seen), 160'(8));
`endif
        shr_en = 1;
        step();
        shr_en = 0;
        c = 0;
        while (cap_req_tready[0] == 1'b0 && c < 3) begin step(); c++; end
        chk("full_reissue", 160'(cap_req_tready), 160'(4'b0001));
        drain("full_drain");

        // head-of-line blocking on port 1
        do_reset();
        shr_en = 0;
        rsp_force = 4'b1101;
        set_req_rand(1, 1);
        wait_tags(1, "hol_fill1");
        set_req_rand(0, 2);
        wait_tags(3, "hol_fill3");
        rsp_log.delete();
        shr_en = 1;
        repeat (4) begin
            step();
            chk("hol_shr_tready", 160'(cap_shr_tready), 160'(0));
            chk("hol_rsp_tvalid", 160'(cap_rsp_tvalid), 160'(4'b0010));
        end
        chk("hol_none_drained", 160'(rsp_log.size()), 160'(0));
        drain("hol_drain");
        chk("hol_drain_count", 160'(rsp_log.size()), 160'(3));
        if (rsp_log.size() == 3) begin
            chk("hol_order0", 160'(rsp_log[0]), 160'(1));
            chk("hol_order1", 160'(rsp_log[1]), 160'(0));
            chk("hol_order2", 160'(rsp_log[2]), 160'(0));
        end

        // orphan result
        force_orphan = 1;
        step();
        chk("orphan_shr_tready", 160'(cap_shr_tready), 160'(0));
        chk("orphan_rsp_tvalid", 160'(cap_rsp_tvalid), 160'(0));
        force_orphan = 0;
        step();
        chk("orphan_err", 160'(cap_err), 160'(1));

        // reset while in HOLD with 3 tags pending
        shr_en = 0;
        set_req_rand(0, 3);
        wait_tags(3, "rst_fill");
        sh_mode = 0;
        set_req_rand(2, 1);
        c = 0;
        while (!cap_sh_tvalid && c < 10) begin step(); c++; end
        chk("rst_in_hold", 160'(cap_sh_tvalid), 160'(1));
        chk("rst_err_before", 160'(cap_err), 160'(1));
        rstn = 1'b0;
        clear_reqs();
        step();
        rstn = 1'b1;
        sh_mode = 1;
        step();
        chk("rst_sh_tvalid_after", 160'(cap_sh_tvalid), 160'(0));
        chk("rst_err_after", 160'(cap_err), 160'(0));
        force_orphan = 1;
        step();
        chk("rst_fifo_empty", 160'(cap_shr_tready), 160'(0));
        force_orphan = 0;
        step();
        chk("rst_late_orphan", 160'(cap_err), 160'(1));

        // randomized traffic
        do_reset();
        rnd_req = 1; rsp_rand = 1; sh_mode = 2; shr_en = 1;
        repeat (3000) step();
        rnd_req = 0;
        clear_reqs();
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
